sd_ctrl_out: RTL and testbench
==============================

Name: sd_ctrl_out

Overview:
- Avalon-MM slave output port that drives SD-card control lines: card power enable, chip-select override and LED.
- Companion to the existing read-only SD status inputs; this block covers the write direction.
- Holds a static output register and supports atomic bit set/clear.
- Provides a timed one-shot pulse engine (e.g. power-cycle the card for N clocks), with a busy flag and an overrun flag readable by the CPU.

Parameters:
- WIDTH, 4, number of output lines (1..31).
- CNT_W, 16, width of the pulse-length counter (1..32).
- RESET_VALUE, 0, value of DATA and out_port after reset (WIDTH bits).
- DEFAULT_LEN, 1000, PULSE_LEN value after reset.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select; read and write are ignored when low.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- read  in  1  read strobe; used only for read side effects.
- readdata  out  32  registered read data.
- out_port  out  WIDTH  registered output lines.

Behaviour:
- Reset is synchronous, active-high and sampled at posedge clk. It forces:
  - DATA=RESET_VALUE, PULSE_LEN=DEFAULT_LEN, MASK=0, cnt=0;
  - state=IDLE, overrun=0, readdata=0, out_port=RESET_VALUE.
- Reset mid-pulse aborts the pulse immediately; out_port=RESET_VALUE on the next cycle.
- Register map (wr = chipselect&write, rd = chipselect&read):
  - addr0 DATA, RW: write loads writedata[WIDTH-1:0]; read returns zero-extended DATA.
  - addr1 PULSE_LEN, RW: write loads writedata[CNT_W-1:0]; read returns zero-extended value.
  - addr2 PULSE, W: write arms a pulse with MASK=writedata[WIDTH-1:0]. Read returns {30'b0, overrun, busy}, and the read clears overrun.
  - addr3 SETCLR, W: writedata[31]=1 gives DATA|=writedata[WIDTH-1:0]; writedata[31]=0 gives DATA&=~writedata[WIDTH-1:0]. Read returns 0.
- readdata is registered: it is updated every cycle with the mux value for the current address, so data is valid 1 cycle after address is presented. No wait states.
- out_port is registered: out_port <= DATA_next ^ (PULSE state ? MASK : 0). A write therefore appears on out_port 1 cycle after the write cycle.
- FSM IDLE:
  - wr to addr2 with PULSE_LEN!=0 and mask!=0: latch MASK, cnt=PULSE_LEN, go to PULSE.
  - PULSE_LEN==0 or mask==0: no pulse, state stays IDLE, no flags set.
- FSM PULSE:
  - cnt decrements each cycle; when cnt==1 go to IDLE and clear MASK.
  - The pulse is visible on out_port for exactly PULSE_LEN cycles.
  - busy=1 while in PULSE.
- Wr to addr2 while in PULSE: ignored (pulse unaffected), overrun set to 1.
- If a read of addr2 and an overrun-setting write occur in the same cycle, set wins.
- Writes to DATA or SETCLR during PULSE update DATA immediately; out_port reflects new DATA^MASK next cycle.
- Writes to PULSE_LEN during PULSE do not alter the running cnt; they take effect on the next pulse.
- If read and write are both asserted in the same cycle, both are honoured. readdata shows the pre-write value.
- Writes with chipselect=0 have no effect.
- Bits of writedata above WIDTH (and above CNT_W for addr1) are ignored, except bit31 at addr3.

Decomposition:
- Shared package sd_ctrl_pkg holds:
  - address constants ADDR_DATA=0, ADDR_LEN=1, ADDR_PULSE=2, ADDR_SETCLR=3;
  - status bit indices BUSY_BIT=0, OVR_BIT=1;
  - FSM state enum {IDLE, PULSE}.
- One sub-module is natural: sd_pulse_timer, containing the FSM, counter, MASK latch and overrun flag.
- The register file, read mux and output register stay in the top.

Test Plan:
- Reset with RESET_VALUE=4'b0001 -> out_port=0001, readdata=0; then read addr1 -> 1000 (DEFAULT_LEN), read addr2 -> 0.
- Write DATA=0xA -> out_port=0xA one cycle later. Then write SETCLR 0x80000001 -> 0xB, and SETCLR 0x00000008 -> 0x3.
- With DATA=0x3, PULSE_LEN=5, write PULSE 0x1 -> out_port=0x2 for exactly 5 cycles, then 0x3. Reading addr2 during the pulse returns 1, after it returns 0.
- During a 5-cycle pulse, write PULSE again -> pulse length unchanged. Read addr2 -> 3, then read again -> 1 (overrun cleared).
- PULSE_LEN=0 or mask=0 then write PULSE -> out_port unchanged, busy never set. Then set PULSE_LEN=3 and assert reset at cycle 2 of the pulse -> out_port=RESET_VALUE next cycle, state IDLE.
- During a pulse with MASK=0x4, write DATA=0xF -> out_port=0xB next cycle, and 0xF after the pulse ends.

Source files
------------

// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD-card control output port: register map,
// status bit positions and pulse-engine state encoding.
package sd_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_PULSE  = 2'd2;
  localparam logic [1:0] ADDR_SETCLR = 2'd3;

  localparam int unsigned BUSY_BIT = 0;
  localparam int unsigned OVR_BIT  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

endpackage

// File: rtl/sd_pulse_timer.sv
// One-shot pulse engine: latches a mask for a programmed number of cycles,
// reports busy, and flags arm attempts made while a pulse is running.
module sd_pulse_timer
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_arm,
  input  logic [WIDTH-1:0] i_mask,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_clr_ovr,
  output logic             o_busy,
  output logic             o_overrun,
  output logic [WIDTH-1:0] o_mask_next
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_next;
  logic             r_ovr;
  logic             w_set_ovr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_mask_next  = r_mask;
    w_set_ovr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_arm && (i_len != '0) && (i_mask != '0)) begin
          w_state_next = PULSE;
          w_cnt_next   = i_len;
          w_mask_next  = i_mask;
        end
      end
      PULSE: begin
        w_set_ovr  = i_arm;
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = IDLE;
          w_mask_next  = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state == PULSE);
    o_overrun   = r_ovr;
    // Next-cycle mask lets the top register out_port in step with the state.
    o_mask_next = w_mask_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_mask <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_mask <= w_mask_next;
      if (w_set_ovr) begin
        r_ovr <= 1'b1;
      end else if (i_clr_ovr) begin
        r_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sd_ctrl_out.sv
// Avalon-MM output port for SD-card control lines: static data register with
// atomic set/clear, plus a timed one-shot pulse XORed onto the outputs.
module sd_ctrl_out
  import sd_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      DEFAULT_LEN = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [CNT_W-1:0] r_len;
  logic [31:0]      w_rd_mux;
  logic             w_busy;
  logic             w_ovr;
  logic [WIDTH-1:0] w_mask_next;
  logic             w_unused_wd;

  assign w_wr        = chipselect & write;
  assign w_rd        = chipselect & read;
  assign w_unused_wd = ^writedata;

  sd_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_arm       (w_wr && (address == ADDR_PULSE)),
    .i_mask      (writedata[WIDTH-1:0]),
    .i_len       (r_len),
    .i_clr_ovr   (w_rd && (address == ADDR_PULSE)),
    .o_busy      (w_busy),
    .o_overrun   (w_ovr),
    .o_mask_next (w_mask_next)
  );

  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_next = writedata[WIDTH-1:0];
        ADDR_SETCLR: w_data_next = writedata[31] ? (r_data | writedata[WIDTH-1:0])
                                                 : (r_data & ~writedata[WIDTH-1:0]);
        default:     w_data_next = r_data;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_data;
      ADDR_LEN:  w_rd_mux[CNT_W-1:0] = r_len;
      ADDR_PULSE: begin
        w_rd_mux[BUSY_BIT] = w_busy;
        w_rd_mux[OVR_BIT]  = w_ovr;
      end
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_len    <= CNT_W'(DEFAULT_LEN);
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      r_data   <= w_data_next;
      if (w_wr && (address == ADDR_LEN)) begin
        r_len <= writedata[CNT_W-1:0];
      end
      readdata <= w_rd_mux;
      out_port <= w_data_next ^ w_mask_next;
    end
  end

endmodule

// File: tb/tb_sd_ctrl_out.sv
// Directed plus randomized bench for sd_ctrl_out, checked against a
// cycle-numbered behavioural model of the register map and pulse window.
module tb_sd_ctrl_out;

  localparam int unsigned WIDTH       = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEFAULT_LEN = 1000;
  localparam logic [3:0]  RV          = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: pulse is active after edge n iff n < m_end.
  logic [3:0]  m_data;
  logic [15:0] m_len;
  logic [3:0]  m_pmask;
  logic        m_ovr;
  int          m_end  = 0;
  int          m_edge = 0;
  logic [31:0] exp_rd;
  logic [3:0]  exp_out;

  sd_ctrl_out #(
    .WIDTH       (WIDTH),
    .CNT_W       (CNT_W),
    .RESET_VALUE (RV),
    .DEFAULT_LEN (DEFAULT_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input logic rst, input logic cs, input logic wr,
                      input logic rd, input logic [1:0] addr, input logic [31:0] wd);
    logic       busy_pre;
    logic [3:0] v;
    reset      = rst;
    chipselect = cs;
    write      = wr;
    read       = rd;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    m_edge++;
    v = wd[3:0];
    if (rst) begin
      m_data  = RV;
      m_len   = 16'(DEFAULT_LEN);
      m_pmask = 4'h0;
      m_ovr   = 1'b0;
      m_end   = 0;
      exp_rd  = '0;
      exp_out = RV;
    end else begin
      busy_pre = (m_edge - 1) < m_end;
      case (addr)
        2'd0:    exp_rd = {28'b0, m_data};
        2'd1:    exp_rd = {16'b0, m_len};
        2'd2:    exp_rd = {30'b0, m_ovr, busy_pre};
        default: exp_rd = '0;
      endcase
      if (cs && wr) begin
        case (addr)
          2'd0: m_data = v;
          2'd1: m_len  = wd[15:0];
          2'd2: begin
            if (busy_pre) m_ovr = 1'b1;
            else if (m_len != 0 && v != 0) begin
              m_end   = m_edge + int'(m_len);
              m_pmask = v;
            end
          end
          default: m_data = wd[31] ? (m_data | v) : (m_data & ~v);
        endcase
      end
      if (cs && rd && addr == 2'd2 && !(wr && busy_pre)) m_ovr = 1'b0;
      exp_out = m_data ^ ((m_edge < m_end) ? m_pmask : 4'h0);
    end
    #1;
    check32({tag, ".out_port"}, {28'b0, out_port}, {28'b0, exp_out});
    check32({tag, ".readdata"}, readdata, exp_rd);
  endtask

  initial begin
    int         pulse_cycles;
    logic [1:0] ra;
    logic [31:0] rwd;

    tick("reset0", 1, 0, 0, 0, 0, 0);
    tick("reset1", 1, 0, 0, 0, 0, 0);
    check32("reset_out", {28'b0, out_port}, 32'h1);
    check32("reset_rd", readdata, 32'h0);
    tick("rd_len", 0, 1, 0, 1, 1, 0);
    check32("default_len", readdata, 32'd1000);
    tick("rd_stat", 0, 1, 0, 1, 2, 0);
    check32("reset_stat", readdata, 32'h0);

    tick("wr_data", 0, 1, 1, 0, 0, 32'hA);
    check32("data_a", {28'b0, out_port}, 32'hA);
    tick("set1", 0, 1, 1, 0, 3, 32'h8000_0001);
    check32("set_b", {28'b0, out_port}, 32'hB);
    tick("clr8", 0, 1, 1, 0, 3, 32'h0000_0008);
    check32("clr_3", {28'b0, out_port}, 32'h3);
    tick("rd_setclr", 0, 1, 0, 1, 3, 0);
    tick("cs_low", 0, 0, 1, 0, 0, 32'hF);

    tick("len5", 0, 1, 1, 0, 1, 5);
    tick("arm5", 0, 1, 1, 0, 2, 32'h1);
    pulse_cycles = (out_port == 4'h2) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick("pulse_rd", 0, 1, 0, 1, 2, 0);
      if (out_port == 4'h2) pulse_cycles++;
    end
    check32("pulse_len5", pulse_cycles, 5);
    check32("pulse_end", {28'b0, out_port}, 32'h3);

    tick("arm_ovr", 0, 1, 1, 0, 2, 32'h1);
    tick("rearm", 0, 1, 1, 0, 2, 32'h1);
    tick("rd_ovr", 0, 1, 0, 1, 2, 0);
    check32("stat_ovr", readdata, 32'h3);
    tick("rd_ovr2", 0, 1, 0, 1, 2, 0);
    check32("stat_cleared", readdata, 32'h1);
    for (int i = 0; i < 5; i++) tick("ovr_drain", 0, 1, 0, 1, 2, 0);

    tick("len0", 0, 1, 1, 0, 1, 0);
    tick("arm_len0", 0, 1, 1, 0, 2, 32'h1);
    tick("rd_len0", 0, 1, 0, 1, 2, 0);
    check32("no_busy_len0", readdata, 32'h0);
    tick("len3", 0, 1, 1, 0, 1, 3);
    tick("arm_mask0", 0, 1, 1, 0, 2, 32'h0);
    tick("rd_mask0", 0, 1, 0, 1, 2, 0);
    check32("no_busy_mask0", readdata, 32'h0);

    tick("arm3", 0, 1, 1, 0, 2, 32'h1);
    tick("mid", 0, 0, 0, 0, 0, 0);
    tick("rst_mid", 1, 0, 0, 0, 0, 0);
    check32("rst_mid_out", {28'b0, out_port}, 32'h1);
    tick("after_rst", 0, 1, 0, 1, 2, 0);
    tick("after_rst2", 0, 1, 0, 1, 2, 0);
    check32("rst_idle", readdata, 32'h0);

    tick("len4", 0, 1, 1, 0, 1, 4);
    tick("arm_m4", 0, 1, 1, 0, 2, 32'h4);
    tick("data_f", 0, 1, 1, 0, 0, 32'hF);
    check32("data_f_pulse", {28'b0, out_port}, 32'hB);
    for (int i = 0; i < 4; i++) tick("m4_drain", 0, 0, 0, 0, 0, 0);
    check32("data_f_end", {28'b0, out_port}, 32'hF);

    for (int i = 0; i < 400; i++) begin
      ra  = 2'($urandom_range(3, 0));
      rwd = (ra == 2'd1) ? 32'($urandom_range(7, 0)) : $urandom;
      tick("rand", ($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0),
           1'($urandom), 1'($urandom), ra, rwd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
